// File: rtl/subservient_uart_pkg.sv
// Shared definitions for the subservient UART transmitter: FSM encoding and 8N1 frame constants.
package subservient_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    localparam logic [2:0] LAST_BIT_IDX = 3'(UART_DATA_BITS - 1);

endpackage

// File: rtl/subservient_uart_fifo.sv
// Small synchronous byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module subservient_uart_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_data
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q;
    logic [FIFO_AW:0] rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;
    assign o_data  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they were written.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/subservient_uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes are serialized LSB-first with a per-frame sampled bit period.
module subservient_uart_tx
    import subservient_uart_pkg::*;
#(
    parameter int FIFO_AW = 2,
    parameter int DIV_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_div,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_tx,
    output logic             o_busy
);

    uart_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             push;
    logic             pop;
    logic             tick;
    logic             load;
    logic [DIV_W-1:0] div_eff;

    assign push    = i_valid & ~fifo_full;
    assign tick    = (cnt_q == '0);
    assign div_eff = (i_div == '0) ? DIV_W'(1) : i_div;
    assign load    = ~fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_STOP && tick));

    assign o_ready = ~fifo_full;
    assign o_tx    = tx_q;
    assign o_busy  = (state_q != ST_IDLE) || ~fifo_empty;

    subservient_uart_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (i_data),
        .i_pop   (pop),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_data  (fifo_head)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_START;
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA:  if (tick && bit_q == LAST_BIT_IDX) state_d = ST_STOP;
            ST_STOP:  if (tick) state_d = fifo_empty ? ST_IDLE : ST_START;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: a load re-samples the divisor; every other bit boundary reuses the latched one.
    always_comb begin
        pop     = 1'b0;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        if (load) begin
            pop     = 1'b1;
            shreg_d = fifo_head;
            div_d   = div_eff;
            cnt_d   = div_eff - DIV_W'(1);
            bit_d   = '0;
            tx_d    = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (tick) begin
                cnt_d = div_q - DIV_W'(1);
                unique case (state_q)
                    ST_START: begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                    ST_DATA: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == LAST_BIT_IDX) begin
                            tx_d = 1'b1;
                        end else begin
                            tx_d    = shreg_q[0];
                            shreg_d = shreg_q >> 1;
                        end
                    end
                    default: tx_d = 1'b1;
                endcase
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_subservient_uart_tx.sv
// Directed bench for subservient_uart_tx: frame shape, timing, back-to-back flow control and reset abort.
module tb_subservient_uart_tx;
    import subservient_uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] div = 16'd4;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        ready;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic tx_log    [0:399];
    logic busy_log  [0:399];
    logic ready_log [0:399];

    subservient_uart_tx #(
        .FIFO_AW (2),
        .DIV_W   (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_div   (div),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready),
        .o_tx    (tx),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n >= UART_FRAME_BITS - 1) return 1'b1;
        return b[n-1];
    endfunction

    task automatic push_byte(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic capture(input int n, input int chg_at, input logic [15:0] chg_val);
        for (int i = 0; i < n; i++) begin
            tx_log[i]    = tx;
            busy_log[i]  = busy;
            ready_log[i] = ready;
            if (i == chg_at) div = chg_val;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input int start, input logic [7:0] b, input int d, input string tag);
        int         mism = 0;
        logic [7:0] obs;
        logic       st, sp;
        for (int p = 0; p < UART_FRAME_BITS * d; p++) begin
            if (tx_log[start+p] !== exp_bit(b, p / d) || busy_log[start+p] !== 1'b1) mism++;
        end
        for (int n = 0; n < 8; n++) obs[n] = tx_log[start + (n + 1) * d + d / 2];
        st = tx_log[start + d / 2];
        sp = tx_log[start + 9 * d + d / 2];
        chk({tag, "_shape"}, mism, 0);
        chk({tag, "_byte"}, obs, b);
        chk({tag, "_framing"}, {st, sp}, 2'b01);
        $display("frame %s: byte 0x%02h decoded as '%c' with %0d-cycle bits", tag, b, obs, d);
    endtask

    initial begin
        int         acc;
        int         acc_edge [6];
        int         mism;
        logic       rdy;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);

        // 1: single byte, 4-cycle bits
        div = 16'd4;
        push_byte(8'h55);
        capture(45, -1, 16'd0);
        chk("t1_busy_on_push", busy_log[0], 1);
        chk("t1_tx_idle_on_push", tx_log[0], 1);
        check_frame(1, 8'h55, 4, "t1");
        chk("t1_busy_last", busy_log[40], 1);
        chk("t1_busy_drop", busy_log[41], 0);

        // 2: 'A' with 10-cycle bits, 100-cycle frame
        div = 16'd10;
        push_byte(8'h41);
        capture(103, -1, 16'd0);
        check_frame(1, 8'h41, 10, "t2");
        chk("t2_busy_last", busy_log[100], 1);
        chk("t2_busy_drop", busy_log[101], 0);

        // 3: continuous valid, bytes 0..5, 3-cycle bits
        div   = 16'd3;
        acc   = 0;
        data  = 8'h00;
        valid = 1'b1;
        for (int t = 1; t <= 190; t++) begin
            rdy = ready;
            @(posedge clk);
            @(negedge clk);
            if (valid && rdy && acc < 6) begin
                acc_edge[acc] = t;
                acc++;
                if (acc == 6) valid = 1'b0;
                else data = acc[7:0];
            end
            tx_log[t]    = tx;
            busy_log[t]  = busy;
            ready_log[t] = ready;
        end
        valid = 1'b0;
        $display("back-to-back: %0d bytes accepted, edges %0d..%0d then %0d", acc, acc_edge[0], acc_edge[4], acc_edge[5]);
        chk("t3_accept_count", acc, 6);
        chk("t3_first_accept", acc_edge[0], 1);
        chk("t3_fifth_accept", acc_edge[4], 5);
        chk("t3_sixth_accept", acc_edge[5], 33);
        chk("t3_ready_full", ready_log[5], 0);
        chk("t3_ready_held", ready_log[31], 0);
        chk("t3_ready_back", ready_log[32], 1);
        mism = 0;
        for (int t = 2; t <= 181; t++) begin
            int f, n;
            f = (t - 2) / 30;
            n = ((t - 2) % 30) / 3;
            if (tx_log[t] !== exp_bit(f[7:0], n) || busy_log[t] !== 1'b1) mism++;
        end
        chk("t3_stream", mism, 0);
        chk("t3_busy_last", busy_log[181], 1);
        chk("t3_busy_drop", busy_log[182], 0);
        chk("t3_tx_idle_after", tx_log[182], 1);

        // 4: divisor 0 behaves as 1
        div = 16'd0;
        push_byte(8'hFF);
        capture(13, -1, 16'd0);
        check_frame(1, 8'hFF, 1, "t4");
        chk("t4_start_low", tx_log[1], 0);
        chk("t4_after_start", tx_log[2], 1);
        chk("t4_busy_last", busy_log[10], 1);
        chk("t4_busy_drop", busy_log[11], 0);

        // 5: divisor 4 -> 8 during the first of two frames
        div   = 16'd4;
        data  = 8'hA5;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        capture(125, 10, 16'd8);
        check_frame(0, 8'hA5, 4, "t5a");
        check_frame(40, 8'h3C, 8, "t5b");
        chk("t5_busy_last", busy_log[119], 1);
        chk("t5_busy_drop", busy_log[120], 0);

        // 6: reset during data bit 3 with a second byte buffered
        div   = 16'd4;
        data  = 8'h00;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        capture(14, -1, 16'd0);
        chk("t6_line_low_bit3", tx_log[13], 0);
        chk("t6_busy_bit3", busy_log[13], 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", tx, 1);
        chk("t6_rst_ready", ready, 1);
        chk("t6_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        capture(60, -1, 16'd0);
        mism = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0 || ready_log[i] !== 1'b1) mism++;
        end
        chk("t6_quiet_after_reset", mism, 0);
        $display("reset abort: %0d idle cycles observed after release", 60 - mism);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
